// File: rtl/mem_pkg.sv
// Shared widths, requester ids and arbitration-mode encodings for the data RAM arbiter.
package mem_pkg;

  localparam int MEM_AW = 9;
  localparam int MEM_DW = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam bit PRIO_RR    = 1'b0;
  localparam bit PRIO_FIXED = 1'b1;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/dpram_512x8.sv
// 512x8 dual-port RAM: write stored at the clock edge, registered read of the pre-edge contents.
// One-cycle read latency, no backpressure; array contents are not reset.
module dpram_512x8
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [MEM_DW-1:0] wdata_i,
  input  logic [MEM_AW-1:0] raddr_i,
  output logic [MEM_DW-1:0] rdata_o
);

  logic [MEM_DW-1:0] mem_q [2**MEM_AW];
  logic [MEM_DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter, combinational one-hot grant; round-robin pointer or fixed A-first.
// The pointer only moves on a contest, handing the next contest to the loser.
module rr_arb2
  import mem_pkg::*;
#(
  parameter bit P_PRIO = PRIO_RR
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (P_PRIO == PRIO_FIXED) begin
      gnt_o[REQ_A] = req_i[REQ_A];
      gnt_o[REQ_B] = req_i[REQ_B] & ~req_i[REQ_A];
    end else if (&req_i) begin
      gnt_o[ptr_q] = 1'b1;
      ptr_d        = ~ptr_q;
    end else begin
      gnt_o = req_i;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) ptr_q <= REQ_A;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arb_2p.sv
// Shares one 512x8 dual-port RAM between A and B; write and read ports arbitrated separately.
// Zero-wait grant when uncontested, read data one cycle after grant; a loser simply holds valid.
module mem_arb_2p
  import mem_pkg::*;
#(
  parameter bit P_PRIO = PRIO_RR
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_a_valid,
  input  logic              i_a_we,
  input  logic [MEM_AW-1:0] i_a_addr,
  input  logic [MEM_DW-1:0] i_a_wdata,
  output logic              o_a_ready,
  output logic              o_a_rvalid,
  output logic [MEM_DW-1:0] o_a_rdata,
  input  logic              i_b_valid,
  input  logic              i_b_we,
  input  logic [MEM_AW-1:0] i_b_addr,
  input  logic [MEM_DW-1:0] i_b_wdata,
  output logic              o_b_ready,
  output logic              o_b_rvalid,
  output logic [MEM_DW-1:0] o_b_rdata
);

  logic [1:0]        wr_req, rd_req, wr_gnt_raw, rd_gnt_raw, wr_gnt, rd_gnt;
  wr_req_t           a_wr, b_wr, wr_sel;
  logic [MEM_AW-1:0] raddr;
  logic [MEM_DW-1:0] ram_rdata, rsp_data;
  logic              ram_we;

  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              fwd_q, fwd_d;
  logic [MEM_DW-1:0] fwd_data_q, fwd_data_d;

  assign wr_req = {i_b_valid & i_b_we,  i_a_valid & i_a_we};
  assign rd_req = {i_b_valid & ~i_b_we, i_a_valid & ~i_a_we};

  rr_arb2 #(.P_PRIO(P_PRIO)) u_wr_arb (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .req_i (wr_req),
    .gnt_o (wr_gnt_raw)
  );

  rr_arb2 #(.P_PRIO(P_PRIO)) u_rd_arb (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .req_i (rd_req),
    .gnt_o (rd_gnt_raw)
  );

  // Grants are held off while reset is asserted so nothing reaches the RAM.
  assign wr_gnt = wr_gnt_raw & {2{i_nrst}};
  assign rd_gnt = rd_gnt_raw & {2{i_nrst}};

  assign o_a_ready = wr_gnt[REQ_A] | rd_gnt[REQ_A];
  assign o_b_ready = wr_gnt[REQ_B] | rd_gnt[REQ_B];

  assign a_wr   = '{addr: i_a_addr, data: i_a_wdata};
  assign b_wr   = '{addr: i_b_addr, data: i_b_wdata};
  assign wr_sel = wr_gnt[REQ_B] ? b_wr : a_wr;
  assign raddr  = rd_gnt[REQ_B] ? i_b_addr : i_a_addr;
  assign ram_we = |wr_gnt;

  dpram_512x8 u_ram (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .we_i   (ram_we),
    .waddr_i(wr_sel.addr),
    .wdata_i(wr_sel.data),
    .raddr_i(raddr),
    .rdata_o(ram_rdata)
  );

  // The RAM returns pre-write contents on a same-edge collision, so that case is forwarded.
  always_comb begin
    rd_pend_d  = |rd_gnt;
    rd_owner_d = rd_gnt[REQ_B] ? REQ_B : REQ_A;
    fwd_d      = ram_we & rd_pend_d & (wr_sel.addr == raddr);
    fwd_data_d = fwd_d ? wr_sel.data : fwd_data_q;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_A;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rsp_data   = fwd_q ? fwd_data_q : ram_rdata;
  assign o_a_rvalid = rd_pend_q & (rd_owner_q == REQ_A);
  assign o_b_rvalid = rd_pend_q & (rd_owner_q == REQ_B);
  assign o_a_rdata  = o_a_rvalid ? rsp_data : '0;
  assign o_b_rdata  = o_b_rvalid ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arb_2p.sv
// Bench for mem_arb_2p: instance 0 round-robin, instance 1 fixed priority, one reference model each.
module tb_mem_arb_2p;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       a_valid [2];
  logic       a_we    [2];
  logic [8:0] a_addr  [2];
  logic [7:0] a_wdata [2];
  logic       b_valid [2];
  logic       b_we    [2];
  logic [8:0] b_addr  [2];
  logic [7:0] b_wdata [2];
  logic [1:0] a_ready, a_rvalid, b_ready, b_rvalid;
  logic [7:0] a_rdata [2];
  logic [7:0] b_rdata [2];

  mem_arb_2p #(.P_PRIO(PRIO_RR)) dut_rr (
    .i_clk(clk), .i_nrst(nrst),
    .i_a_valid(a_valid[0]), .i_a_we(a_we[0]), .i_a_addr(a_addr[0]), .i_a_wdata(a_wdata[0]),
    .o_a_ready(a_ready[0]), .o_a_rvalid(a_rvalid[0]), .o_a_rdata(a_rdata[0]),
    .i_b_valid(b_valid[0]), .i_b_we(b_we[0]), .i_b_addr(b_addr[0]), .i_b_wdata(b_wdata[0]),
    .o_b_ready(b_ready[0]), .o_b_rvalid(b_rvalid[0]), .o_b_rdata(b_rdata[0])
  );

  mem_arb_2p #(.P_PRIO(PRIO_FIXED)) dut_fx (
    .i_clk(clk), .i_nrst(nrst),
    .i_a_valid(a_valid[1]), .i_a_we(a_we[1]), .i_a_addr(a_addr[1]), .i_a_wdata(a_wdata[1]),
    .o_a_ready(a_ready[1]), .o_a_rvalid(a_rvalid[1]), .o_a_rdata(a_rdata[1]),
    .i_b_valid(b_valid[1]), .i_b_we(b_we[1]), .i_b_addr(b_addr[1]), .i_b_wdata(b_wdata[1]),
    .o_b_ready(b_ready[1]), .o_b_rvalid(b_rvalid[1]), .o_b_rdata(b_rdata[1])
  );

  // Reference state: memory image, pending response, and who wins the next contest per port.
  logic [7:0] mdl_mem [2][512];
  bit         exp_rv  [2][2];
  logic [7:0] exp_rd  [2][2];
  bit         win_b_w [2];
  bit         win_b_r [2];
  bit         got_a   [2];
  bit         got_b   [2];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input int m, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      exp_rv[m][0] = 1'b0; exp_rv[m][1] = 1'b0;
      exp_rd[m][0] = 8'h00; exp_rd[m][1] = 8'h00;
      win_b_w[m] = 1'b0; win_b_r[m] = 1'b0;
      got_a[m] = 1'b0; got_b[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m);
    bit wa, wb, ra, rb, gwa, gwb, gra, grb, fixed;
    logic [8:0] wadr, radr;
    logic [7:0] wd, rd;
    fixed = (m == 1);
    wa = a_valid[m] && a_we[m];
    wb = b_valid[m] && b_we[m];
    ra = a_valid[m] && !a_we[m];
    rb = b_valid[m] && !b_we[m];
    gwa = nrst && wa && (!wb || fixed || !win_b_w[m]);
    gwb = nrst && wb && !gwa;
    gra = nrst && ra && (!rb || fixed || !win_b_r[m]);
    grb = nrst && rb && !gra;
    chk("a_ready", m, {7'b0, a_ready[m]}, {7'b0, gwa | gra});
    chk("b_ready", m, {7'b0, b_ready[m]}, {7'b0, gwb | grb});
    chk("a_rvalid", m, {7'b0, a_rvalid[m]}, {7'b0, exp_rv[m][0]});
    chk("b_rvalid", m, {7'b0, b_rvalid[m]}, {7'b0, exp_rv[m][1]});
    chk("a_rdata", m, a_rdata[m], exp_rd[m][0]);
    chk("b_rdata", m, b_rdata[m], exp_rd[m][1]);
    got_a[m] = gwa | gra;
    got_b[m] = gwb | grb;
    if (!nrst) begin
      exp_rv[m][0] = 1'b0; exp_rv[m][1] = 1'b0;
      exp_rd[m][0] = 8'h00; exp_rd[m][1] = 8'h00;
      win_b_w[m] = 1'b0; win_b_r[m] = 1'b0;
    end else begin
      wadr = gwb ? b_addr[m] : a_addr[m];
      wd   = gwb ? b_wdata[m] : a_wdata[m];
      radr = grb ? b_addr[m] : a_addr[m];
      rd   = mdl_mem[m][radr];
      if ((gwa || gwb) && wadr == radr) rd = wd;
      if (gwa || gwb) mdl_mem[m][wadr] = wd;
      exp_rv[m][0] = gra; exp_rv[m][1] = grb;
      exp_rd[m][0] = gra ? rd : 8'h00;
      exp_rd[m][1] = grb ? rd : 8'h00;
      if (wa && wb) win_b_w[m] = gwa;
      if (ra && rb) win_b_r[m] = gra;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    #1;
    for (int m = 0; m < 2; m++) model_step(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input int m, input bit v, input bit we, input logic [8:0] ad, input logic [7:0] d);
    a_valid[m] = v; a_we[m] = we; a_addr[m] = ad; a_wdata[m] = d;
  endtask

  task automatic set_b(input int m, input bit v, input bit we, input logic [8:0] ad, input logic [7:0] d);
    b_valid[m] = v; b_we[m] = we; b_addr[m] = ad; b_wdata[m] = d;
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      set_a(m, 0, 0, 9'h000, 8'h00);
      set_b(m, 0, 0, 9'h000, 8'h00);
    end
  endtask

  initial begin
    nrst = 1'b0;
    idle_all();
    model_clear();
    @(negedge clk);
    // Requests during reset must not be granted.
    for (int m = 0; m < 2; m++) set_a(m, 1, 1, 9'h010, 8'hEE);
    tick();
    nrst = 1'b1;
    idle_all();
    tick();

    for (int i = 0; i < 512; i++) begin
      logic [8:0] ad;
      ad = 9'(i);
      for (int m = 0; m < 2; m++) set_a(m, 1, 1, ad, 8'(i * 7 + 3));
      tick();
    end
    idle_all();
    tick();

    // A write then read back.
    for (int m = 0; m < 2; m++) set_a(m, 1, 1, 9'h010, 8'h5A);
    tick();
    for (int m = 0; m < 2; m++) set_a(m, 1, 0, 9'h010, 8'h00);
    tick();
    idle_all();
    for (int m = 0; m < 2; m++) chk("t1_const", m, a_rdata[m], 8'h5A);
    tick();

    // Same-cycle read/write collision is forwarded.
    for (int m = 0; m < 2; m++) begin
      set_a(m, 1, 0, 9'h020, 8'h00);
      set_b(m, 1, 1, 9'h020, 8'hC3);
    end
    tick();
    idle_all();
    for (int m = 0; m < 2; m++) chk("t2_fwd", m, a_rdata[m], 8'hC3);
    tick();

    // Read contest: rr alternates from A (odd count leaves pointer at B), fixed always grants A.
    for (int i = 0; i < 5; i++) begin
      for (int m = 0; m < 2; m++) begin
        set_a(m, 1, 0, 9'h030, 8'h00);
        set_b(m, 1, 0, 9'h031, 8'h00);
      end
      #1;
      chk("rr_alt", 0, {7'b0, a_ready[0]}, {7'b0, i % 2 == 0});
      chk("fx_b_wait", 1, {7'b0, b_ready[1]}, 8'h00);
      tick();
    end
    for (int m = 0; m < 2; m++) set_a(m, 0, 0, 9'h000, 8'h00);
    #1;
    chk("fx_b_go", 1, {7'b0, b_ready[1]}, 8'h01);
    tick();
    idle_all();
    tick();

    // Top address write alongside a low-address read.
    for (int m = 0; m < 2; m++) set_a(m, 1, 1, 9'h000, 8'h11);
    tick();
    for (int m = 0; m < 2; m++) begin
      set_a(m, 1, 0, 9'h000, 8'h00);
      set_b(m, 1, 1, 9'h1FF, 8'h77);
    end
    tick();
    idle_all();
    for (int m = 0; m < 2; m++) chk("t4_rd0", m, a_rdata[m], 8'h11);
    tick();
    for (int m = 0; m < 2; m++) set_a(m, 1, 0, 9'h1FF, 8'h00);
    tick();
    idle_all();
    for (int m = 0; m < 2; m++) chk("t4_rd1ff", m, a_rdata[m], 8'h77);
    tick();

    // Reset while a read response is on the outputs.
    for (int m = 0; m < 2; m++) set_a(m, 1, 0, 9'h010, 8'h00);
    tick();
    idle_all();
    nrst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) chk("rst_rvalid", m, {7'b0, a_rvalid[m]}, 8'h00);
    model_clear();
    tick();
    nrst = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      set_a(m, 1, 0, 9'h030, 8'h00);
      set_b(m, 1, 0, 9'h031, 8'h00);
    end
    #1;
    chk("rst_ptr", 0, {7'b0, a_ready[0]}, 8'h01);
    tick();
    idle_all();
    tick();
    for (int m = 0; m < 2; m++) set_a(m, 1, 0, 9'h010, 8'h00);
    tick();
    idle_all();
    for (int m = 0; m < 2; m++) chk("rst_keep", m, a_rdata[m], 8'h5A);
    tick();

    // Random traffic on a narrow address window to provoke contests and collisions.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (got_a[m] || !a_valid[m])
          set_a(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                9'($urandom_range(0, 15)), 8'($urandom));
        if (got_b[m] || !b_valid[m])
          set_b(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                9'($urandom_range(0, 15)), 8'($urandom));
      end
      tick();
    end
    idle_all();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arb_2p.md
# mem_arb_2p

Two-requester arbiter and sequencer for the 512x8 dual-port data RAM. It lets the CPU core (requester A) and the UART debug/loader (requester B) share one RAM instance without external glue. The write port and the read port are arbitrated independently, so one requester can read while the other writes in the same cycle. Same-cycle read-after-write to one address is resolved by forwarding. The block instantiates the RAM internally.

## Interface
- P_PRIO, 0 — 0: round-robin per port; 1: fixed priority, A always wins.
- i_clk  in  1  clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_a_valid  in  1  A request present.
- i_a_we  in  1  A request is a write (1) or a read (0).
- i_a_addr  in  9  A byte address.
- i_a_wdata  in  8  A write data.
- o_a_ready  out  1  A request accepted this cycle (grant).
- o_a_rvalid  out  1  A read data valid.
- o_a_rdata  out  8  A read data.
- i_b_valid, i_b_we, i_b_addr, i_b_wdata, o_b_ready, o_b_rvalid, o_b_rdata — same as A, for requester B.

## Operation
- A request transfers when valid and ready are both high at a rising edge. The requester holds addr, we and wdata stable until ready.
- Write arbiter:
  - Candidates are requesters with valid=1 and we=1.
  - The winner drives the RAM we, waddr and wdata.
- Read arbiter:
  - Candidates are requesters with valid=1 and we=0.
  - The winner drives the RAM raddr.
  - A registered tag (rd_owner) records the winner, and rd_pend is set.
- Each requester presents one request, so at most one winner per port. A read by one requester and a write by the other are both granted in the same cycle.
- Round-robin (P_PRIO=0):
  - There is one priority pointer per port; it resets to A.
  - When a port has two candidates, the pointer's side wins. After the grant the pointer moves to the loser.
  - A grant with only one candidate leaves the pointer unchanged.
- Fixed priority (P_PRIO=1): A wins every contest. B waits with valid held high.
- Forwarding:
  - Applies when a read and a write are granted in the same cycle to the same address.
  - The write data is captured into fwd_data and fwd_q is set.
  - The next cycle's rdata is fwd_data, not the RAM output.
  - Read-after-write to the same address in the following cycle needs no forwarding, because the RAM write completes at the grant edge.
- Read response:
  - o_x_rvalid = rd_pend and (rd_owner == x).
  - o_x_rdata = (fwd_q ? fwd_data : ram_rdata) when o_x_rvalid is high, else 8'h00.
- Reset:
  - Clears pointers (to A), rd_pend, rd_owner, fwd_q and fwd_data.
  - A read in flight at reset assertion is dropped; no rvalid is produced.
  - RAM contents are not reset.
  - While i_nrst is low, both o_x_ready outputs are forced to 0, so no write reaches the RAM.

## Timing
- o_x_ready is combinational from the valid/we inputs and the pointers, so a request is granted in the same cycle with zero wait cycles when uncontested.
- Write latency: data is stored at the grant edge.
- Read latency: a grant in cycle N gives o_x_rvalid high for exactly cycle N+1 with the data. This holds for back-to-back reads on every cycle.
- A contested loser waits at least one cycle. With round-robin it is guaranteed the grant on the next contest.
- Reset values: o_a_ready=0, o_b_ready=0, o_a_rvalid=0, o_b_rvalid=0, o_a_rdata=8'h00, o_b_rdata=8'h00.

## Structure
- Shared package (mem_pkg):
  - MEM_AW=9, MEM_DW=8.
  - Requester id constants REQ_A=1'b0 and REQ_B=1'b1.
  - P_PRIO encodings PRIO_RR=0 and PRIO_FIXED=1.
- Sub-module rr_arb2: a 2-way arbiter with a pointer register, instantiated twice (write port and read port). Inputs: req[1:0], parameter P_PRIO. Output: one-hot gnt[1:0].
- RAM: one instance of the existing 512x8 dual-port memory. Its single i_clk and i_nrst are shared with the arbiter.

## Test plan
- A writes 0x5A to addr 0x010, then reads addr 0x010 on the next cycle. Required: o_a_ready high on both cycles, o_a_rvalid on the cycle after the read with o_a_rdata=0x5A, o_b_rvalid stays 0.
- A reads 0x020 while B writes 0xC3 to 0x020 in the same cycle. Required: both readies high, next cycle o_a_rdata=0xC3 through forwarding.
- P_PRIO=0, A and B both read continuously, addresses pre-loaded with distinct values. Required: grants alternate A,B,A,B starting with A, and each rvalid/rdata pair matches its owner's address.
- P_PRIO=1, same stimulus as the round-robin contest. Required: A granted every cycle, B ready=0 until A drops valid, then B is granted the same cycle.
- B writes 0x1FF=0x77 while A reads 0x000=0x11. Required: both granted, next cycle o_a_rdata=0x11, and a later read of 0x1FF returns 0x77.
- Assert i_nrst mid-sequence, in the cycle after a read grant. Required: rvalid 0 and rdata 0x00 immediately, no response after release, pointer back to A, previously written RAM data still readable.
